// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the FP mantissa add/subtract sequencer.
package fp_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] PASSES_SINGLE = 2'd1;
  localparam logic [1:0] PASSES_DOUBLE = 2'd2;

endpackage

// File: rtl/Nbit_FullAdder.sv
// N-bit ripple-carry adder built from a chain of 1-bit full adders.
// Purely combinational; the carry out of the top bit is returned as co.
module Nbit_FullAdder #(
  parameter int N = 8
) (
  output logic [N-1:0] sum,
  output logic         co,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci
);

  logic [N:0] carry;

  assign carry[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

  assign co = carry[N];

endmodule

// File: rtl/addsub_mag_seq.sv
// Signed-magnitude add/subtract sequencer for the FP mantissa path.
// A single shared ripple adder is used for one pass (add, or subtract with
// A >= B) or two passes (subtract with B > A, where the second pass turns
// the negative two's-complement difference back into a magnitude).
module addsub_mag_seq
  import fp_addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         a_sign,
  input  logic [N-1:0] a_mag,
  input  logic         b_sign,
  input  logic [N-1:0] b_mag,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         res_sign,
  output logic [N-1:0] res_mag,
  output logic         res_ovf,
  output logic         res_zero,
  output logic [1:0]   res_passes
);

  seq_state_t state_q, state_d;

  // Latched operand bundle
  logic         a_sign_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         eff_sub_q;

  // Pass-1 difference kept for the negation pass
  logic [N-1:0] sum_q;

  // Shared adder ports
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_ci;
  logic [N-1:0] add_sum;
  logic         add_co;

  Nbit_FullAdder #(.N(N)) u_adder (
    .sum (add_sum),
    .co  (add_co),
    .a   (add_a),
    .b   (add_b),
    .ci  (add_ci)
  );

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic, adder input muxing and handshake outputs
  always_comb begin
    state_d   = state_q;
    add_a     = a_q;
    add_b     = eff_sub_q ? ~b_q : b_q;
    add_ci    = eff_sub_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = PASS1;
      end
      PASS1: begin
        // No carry out of A + ~B + 1 means B > A: the sum is negative
        state_d = (eff_sub_q && !add_co) ? PASS2 : DONE;
      end
      PASS2: begin
        add_a   = ~sum_q;
        add_b   = '0;
        add_ci  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept and pass-1 sum capture
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_sign_q  <= a_sign;
      a_q       <= a_mag;
      b_q       <= b_mag;
      eff_sub_q <= a_sign ^ b_sign ^ op_sub;
    end
    if (state_q == PASS1) sum_q <= add_sum;
  end

  // Result registers, updated only on the transitions into DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_sign   <= 1'b0;
      res_mag    <= '0;
      res_ovf    <= 1'b0;
      res_zero   <= 1'b0;
      res_passes <= 2'd0;
    end else if (state_q == PASS1 && !(eff_sub_q && !add_co)) begin
      // A zero result is always reported as +0
      res_mag    <= add_sum;
      res_ovf    <= ~eff_sub_q & add_co;
      res_zero   <= (add_sum == '0);
      res_sign   <= a_sign_q & (add_sum != '0);
      res_passes <= PASSES_SINGLE;
    end else if (state_q == PASS2) begin
      res_mag    <= add_sum;
      res_ovf    <= 1'b0;
      res_zero   <= (add_sum == '0);
      res_sign   <= ~a_sign_q & (add_sum != '0);
      res_passes <= PASSES_DOUBLE;
    end
  end

endmodule

// File: tb/tb_addsub_mag_seq.sv
// Directed testbench for addsub_mag_seq with hand-computed expected results.
module tb_addsub_mag_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         a_sign;
  logic [N-1:0] a_mag;
  logic         b_sign;
  logic [N-1:0] b_mag;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic         res_sign;
  logic [N-1:0] res_mag;
  logic         res_ovf;
  logic         res_zero;
  logic [1:0]   res_passes;

  int checks   = 0;
  int failures = 0;

  addsub_mag_seq #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_sign     (a_sign),
    .a_mag      (a_mag),
    .b_sign     (b_sign),
    .b_mag      (b_mag),
    .op_sub     (op_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_sign   (res_sign),
    .res_mag    (res_mag),
    .res_ovf    (res_ovf),
    .res_zero   (res_zero),
    .res_passes (res_passes)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic as, input logic [N-1:0] am,
                          input logic bs, input logic [N-1:0] bm, input logic sub);
    a_sign   = as;
    a_mag    = am;
    b_sign   = bs;
    b_mag    = bm;
    op_sub   = sub;
    in_valid = 1'b1;
  endtask

  // Issue one operation, wait for the result, check it and optionally consume it
  task automatic run_op(input string tag,
                        input logic as, input logic [N-1:0] am,
                        input logic bs, input logic [N-1:0] bm, input logic sub,
                        input logic [N-1:0] e_mag, input logic e_sign,
                        input logic e_ovf, input logic e_zero,
                        input logic [1:0] e_passes, input int e_lat,
                        input bit consume);
    int edges;
    chk({tag, ".in_ready"}, in_ready, 1);
    drive_op(as, am, bs, bm, sub);
    edges = 0;
    do begin
      tick();
      in_valid = 1'b0;
      edges++;
    end while (!out_valid && edges < 10);
    chk({tag, ".latency"}, edges, e_lat);
    chk({tag, ".mag"}, res_mag, e_mag);
    chk({tag, ".sign"}, res_sign, e_sign);
    chk({tag, ".ovf"}, res_ovf, e_ovf);
    chk({tag, ".zero"}, res_zero, e_zero);
    chk({tag, ".passes"}, res_passes, e_passes);
    if (consume) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".valid_drop"}, out_valid, 0);
      chk({tag, ".ready_back"}, in_ready, 1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_sign    = 1'b0;
    a_mag     = '0;
    b_sign    = 1'b0;
    b_mag     = '0;
    op_sub    = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.res", {res_sign, res_mag, res_ovf, res_zero, res_passes}, 0);
    rst_n = 1'b1;
    tick();

    //     tag          as  am   bs  bm   sub  mag   sign ovf zero pass lat
    run_op("p4m10",    0,  4,   0,  10,  1,   6,    1,   0,  0,   2,   3, 1);
    run_op("p10m4",    0,  10,  0,  4,   1,   6,    0,   0,  0,   1,   2, 1);
    run_op("n4pn10",   1,  4,   1,  10,  0,   14,   1,   0,  0,   1,   2, 1);
    run_op("p200pp100",0,  200, 0,  100, 0,   8'h2C,0,   1,  0,   1,   2, 1);
    run_op("p7m7",     0,  7,   0,  7,   1,   0,    0,   0,  1,   1,   2, 1);
    run_op("n7pp7",    1,  7,   0,  7,   0,   0,    0,   0,  1,   1,   2, 1);
    run_op("n5mp3",    1,  5,   0,  3,   1,   8,    1,   0,  0,   1,   2, 1);
    run_op("n3mn9",    1,  3,   1,  9,   1,   6,    0,   0,  0,   2,   3, 1);

    // Backpressure: hold the result while a new operand is offered
    run_op("bp",       0,  10,  0,  4,   1,   6,    0,   0,  0,   1,   2, 0);
    drive_op(0, 8'd50, 0, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold_valid", out_valid, 1);
      chk("bp.hold_ready", in_ready, 0);
      chk("bp.hold_res", {res_sign, res_mag, res_ovf, res_zero, res_passes},
          {1'b0, 8'd6, 1'b0, 1'b0, 2'd1});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.release_valid", out_valid, 0);
    tick();
    chk("bp.no_ghost", out_valid, 0);
    run_op("reload",   0,  9,   0,  3,   0,   12,   0,   0,  0,   1,   2, 1);

    // Reset during the second pass abandons the operation
    drive_op(0, 8'd4, 0, 8'd10, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.res", {res_sign, res_mag, res_ovf, res_zero, res_passes}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst.no_valid", out_valid, 0);
    end
    run_op("post_rst", 0,  20,  1,  5,   1,   25,   0,   0,  0,   1,   2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
